// File: rtl/cpu_regfile_flags_if.sv
// ---------------------------------------------------------------------------
// cpu_regfile_flags_if
// Bundle of the select, write-back, flag and output-port signals that
// connect the CPU controller/ALU (master) to the operand and write-back
// stage (slave).
//
// Signals:
//   ra_sel, rb_sel  read selects for operands A and B
//   wr_sel, we      write-back register select and enable
//   wr_src          write data select: 0 = t (ALU result), 1 = din
//   t, din          ALU result and external input data
//   cf_in, zf_in    ALU carry and zero flags
//   flag_we         flag register load enable
//   out_we          output port load enable
//   a_out, b_out    operands to the ALU (combinational)
//   cf, zf          registered flags
//   dout            registered output port
// ---------------------------------------------------------------------------
interface cpu_regfile_flags_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] ra_sel;
  logic [ADDR_W-1:0] rb_sel;
  logic [ADDR_W-1:0] wr_sel;
  logic              we;
  logic              wr_src;
  logic [WIDTH-1:0]  t;
  logic [WIDTH-1:0]  din;
  logic              cf_in;
  logic              zf_in;
  logic              flag_we;
  logic              out_we;
  logic [WIDTH-1:0]  a_out;
  logic [WIDTH-1:0]  b_out;
  logic              cf;
  logic              zf;
  logic [WIDTH-1:0]  dout;

  // Controller / ALU side.
  modport master (
    output ra_sel, rb_sel, wr_sel, we, wr_src, t, din,
           cf_in, zf_in, flag_we, out_we,
    input  a_out, b_out, cf, zf, dout
  );

  // Register file side.
  modport slave (
    input  ra_sel, rb_sel, wr_sel, we, wr_src, t, din,
           cf_in, zf_in, flag_we, out_we,
    output a_out, b_out, cf, zf, dout
  );
endinterface

// File: rtl/cpu_regfile_flags.sv
// ---------------------------------------------------------------------------
// cpu_regfile_flags
// Operand and write-back stage of the 8-bit CPU datapath: a small register
// file feeding the ALU operands combinationally, write-back of the ALU
// result or external data, a persistent carry/zero flag register and a
// registered output port that latches operand B.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  cpu_regfile_flags_if.slave (selects, write-back, flags, dout)
//
// Configuration:
//   CPU_REGFILE_WRITE_BYPASS_EN - when defined, a write in flight to the
//   register selected by a read port is forwarded combinationally to that
//   read port (and thus into dout). Undefined by default.
// ---------------------------------------------------------------------------
module cpu_regfile_flags #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input logic                clk,
  input logic                rst,
  cpu_regfile_flags_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic             cf_q;
  logic             zf_q;
  logic [WIDTH-1:0] dout_q;

  assign wr_data = bus.wr_src ? bus.din : bus.t;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    a_val = regs[bus.ra_sel];
    b_val = regs[bus.rb_sel];
`ifdef CPU_REGFILE_WRITE_BYPASS_EN
    // Forwarding is suppressed in reset so the read ports still show the
    // cleared registers.
    if (bus.we && !rst && (bus.wr_sel == bus.ra_sel)) a_val = wr_data;
    if (bus.we && !rst && (bus.wr_sel == bus.rb_sel)) b_val = wr_data;
`endif
  end

  // NOTE: the register array is built from flops, not a RAM macro, so it
  // takes the asynchronous reset like the rest of the state; all state uses
  // non-blocking assignments so same-edge reads see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      if (bus.we) regs[bus.wr_sel] <= wr_data;
      if (bus.flag_we) begin
        cf_q <= bus.cf_in;
        zf_q <= bus.zf_in;
      end
      // b_val is the pre-edge (or bypassed) operand, not the new write.
      if (bus.out_we) dout_q <= b_val;
    end
  end

  assign bus.a_out = a_val;
  assign bus.b_out = b_val;
  assign bus.cf    = cf_q;
  assign bus.zf    = zf_q;
  assign bus.dout  = dout_q;
endmodule

// File: tb/tb_cpu_regfile_flags.sv
// ---------------------------------------------------------------------------
// tb_cpu_regfile_flags
// Directed self-checking bench for cpu_regfile_flags. Expected values are
// hand-computed constants; the bypass build changes only the same-cycle
// forwarding expectations.
// ---------------------------------------------------------------------------
module tb_cpu_regfile_flags;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;

`ifdef CPU_REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu_regfile_flags_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  cpu_regfile_flags #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] sel,
                           input logic [WIDTH-1:0] data);
    bus.we = 1'b1; bus.wr_src = 1'b1; bus.wr_sel = sel; bus.din = data;
    step();
    bus.we = 1'b0;
  endtask

  task automatic read_a(input logic [ADDR_W-1:0] sel,
                        output logic [WIDTH-1:0] val);
    bus.ra_sel = sel;
    #1;
    val = bus.a_out;
  endtask

  logic [WIDTH-1:0] v;

  initial begin
    bus.ra_sel = '0; bus.rb_sel = '0; bus.wr_sel = '0;
    bus.we = 1'b0; bus.wr_src = 1'b0; bus.t = '0; bus.din = '0;
    bus.cf_in = 1'b0; bus.zf_in = 1'b0; bus.flag_we = 1'b0; bus.out_we = 1'b0;

    // Reset state.
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_a_out", bus.a_out, 8'h00);
    check("rst_b_out", bus.b_out, 8'h00);
    check("rst_cf", bus.cf, 1'b0);
    check("rst_zf", bus.zf, 1'b0);
    check("rst_dout", bus.dout, 8'h00);

    // Load state, then async reset mid-cycle.
    write_reg(2'd1, 8'h5A);
    bus.cf_in = 1'b1; bus.zf_in = 1'b1; bus.flag_we = 1'b1;
    bus.rb_sel = 2'd1; bus.out_we = 1'b1;
    step();
    bus.flag_we = 1'b0; bus.out_we = 1'b0;
    read_a(2'd1, v);
    check("pre_rst_reg1", v, 8'h5A);
    check("pre_rst_dout", bus.dout, 8'h5A);
    check("pre_rst_cf", bus.cf, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_a_out", bus.a_out, 8'h00);
    check("async_rst_cf", bus.cf, 1'b0);
    check("async_rst_zf", bus.zf, 1'b0);
    check("async_rst_dout", bus.dout, 8'h00);
    // Writes while reset is held are lost.
    bus.we = 1'b1; bus.wr_src = 1'b1; bus.wr_sel = 2'd0; bus.din = 8'h77;
    bus.flag_we = 1'b1; bus.out_we = 1'b1;
    step();
    bus.we = 1'b0; bus.flag_we = 1'b0; bus.out_we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_a(i[ADDR_W-1:0], v);
      check($sformatf("post_rst_reg%0d", i), v, 8'h00);
    end
    check("post_rst_cf", bus.cf, 1'b0);
    check("post_rst_dout", bus.dout, 8'h00);

    // Write/read: only the selected register changes.
    write_reg(2'd2, 8'h3C);
    read_a(2'd2, v); check("wr_reg2", v, 8'h3C);
    read_a(2'd0, v); check("wr_reg0_untouched", v, 8'h00);
    read_a(2'd1, v); check("wr_reg1_untouched", v, 8'h00);
    read_a(2'd3, v); check("wr_reg3_untouched", v, 8'h00);
    // we=0 holds even with din changing.
    bus.din = 8'hA5; bus.wr_sel = 2'd2;
    step();
    read_a(2'd2, v); check("hold_reg2", v, 8'h3C);

    // ALU write-back and flags.
    write_reg(2'd0, 8'h80);
    write_reg(2'd1, 8'h80);
    write_reg(2'd3, 8'hEE);
    bus.ra_sel = 2'd0; bus.rb_sel = 2'd1;
    #1;
    check("alu_a_out", bus.a_out, 8'h80);
    check("alu_b_out", bus.b_out, 8'h80);
    bus.t = 8'h00; bus.din = 8'hFF; bus.wr_src = 1'b0;
    bus.cf_in = 1'b1; bus.zf_in = 1'b1; bus.flag_we = 1'b1;
    bus.we = 1'b1; bus.wr_sel = 2'd3;
    step();
    bus.we = 1'b0; bus.flag_we = 1'b0;
    bus.cf_in = 1'b0; bus.zf_in = 1'b0;
    read_a(2'd3, v); check("alu_wb_reg3", v, 8'h00);
    check("alu_cf_set", bus.cf, 1'b1);
    check("alu_zf_set", bus.zf, 1'b1);
    step();
    check("flags_hold_cf", bus.cf, 1'b1);
    check("flags_hold_zf", bus.zf, 1'b1);
    bus.cf_in = 1'b0; bus.zf_in = 1'b1; bus.flag_we = 1'b1;
    step();
    bus.flag_we = 1'b0;
    check("flags_mixed_cf", bus.cf, 1'b0);
    check("flags_mixed_zf", bus.zf, 1'b1);
    // ALU path with a nonzero value.
    bus.t = 8'hC3; bus.wr_src = 1'b0; bus.we = 1'b1; bus.wr_sel = 2'd2;
    step();
    bus.we = 1'b0;
    read_a(2'd2, v); check("alu_wb_reg2", v, 8'hC3);

    // Same-index read during write.
    write_reg(2'd1, 8'h11);
    bus.ra_sel = 2'd1;
    bus.we = 1'b1; bus.wr_src = 1'b1; bus.wr_sel = 2'd1; bus.din = 8'h22;
    #1;
    check("rdw_before_edge", bus.a_out, BYPASS ? 8'h22 : 8'h11);
    step();
    bus.we = 1'b0;
    check("rdw_after_edge", bus.a_out, 8'h22);

    // Output port captures pre-edge operand B.
    write_reg(2'd1, 8'h11);
    bus.rb_sel = 2'd1;
    bus.out_we = 1'b1;
    bus.we = 1'b1; bus.wr_src = 1'b1; bus.wr_sel = 2'd1; bus.din = 8'h99;
    step();
    bus.out_we = 1'b0; bus.we = 1'b0;
    check("out_dout", bus.dout, BYPASS ? 8'h99 : 8'h11);
    check("out_reg1", bus.b_out, 8'h99);
    write_reg(2'd1, 8'h44);
    check("out_hold_dout", bus.dout, BYPASS ? 8'h99 : 8'h11);
    check("out_hold_reg1", bus.b_out, 8'h44);
    // ra_sel == rb_sel gives the same value on both ports.
    bus.ra_sel = 2'd1;
    #1;
    check("same_sel_a", bus.a_out, 8'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
